// File: rtl/cv32e40p_pkg2_ft.sv
// Shared definitions for the fault-tolerance supervisor: register map and FSM encoding.
package cv32e40p_pkg2_ft;

  localparam logic [7:0] FTS_STATUS   = 8'h00;
  localparam logic [7:0] FTS_CTRL     = 8'h01;
  localparam logic [7:0] FTS_BLK_BASE = 8'h10;
  localparam logic [7:0] FTS_DET      = 8'h00;
  localparam logic [7:0] FTS_COR      = 8'h01;
  localparam logic [7:0] FTS_BROKEN   = 8'h02;
  localparam logic [7:0] FTS_FORCE    = 8'h03;

  typedef enum logic [0:0] {
    FTS_IDLE,
    FTS_CLEAR
  } fts_state_e;

  // Fatal when at least two of the three replica lanes are broken.
  function automatic logic fts_fatal(input logic [2:0] lanes);
    return (lanes[0] & lanes[1]) | (lanes[0] & lanes[2]) | (lanes[1] & lanes[2]);
  endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// Saturating error counter; clear takes priority over increment.
module cv32e40p_ft_err_counter #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_supervisor.sv
// Fault-tolerance supervisor: per-wrapper error counters, broken-lane pending/irq,
// forced-broken control and a single-cycle request/grant register port.
module cv32e40p_ft_supervisor
  import cv32e40p_pkg2_ft::*;
#(
  parameter int unsigned N_BLOCKS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_BLOCKS-1:0]   err_detected_i,
  input  logic [N_BLOCKS-1:0]   err_corrected_i,
  input  logic [3*N_BLOCKS-1:0] is_broken_i,
  output logic [3*N_BLOCKS-1:0] set_broken_o,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [7:0]            addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  irq_o
);

  fts_state_e            state_q, state_d;
  logic [3:0]            clr_idx_q, clr_idx_d;
  logic [N_BLOCKS-1:0]   status_q, status_d, edge_blk, cnt_clr;
  logic [3*N_BLOCKS-1:0] force_q, force_d, brk_q, edge_q;
  logic                  irq_en_q, irq_en_d, init_q, rvalid_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  gnt, wr;
  logic [CNT_W-1:0]      det_cnt [N_BLOCKS];
  logic [CNT_W-1:0]      cor_cnt [N_BLOCKS];
  logic                  unused_wdata;

  assign unused_wdata = ^wdata_i;

  assign gnt = rst_n & req_i & (state_q == FTS_IDLE);
  assign wr  = gnt & we_i;

  for (genvar b = 0; b < N_BLOCKS; b++) begin : g_blk
    assign cnt_clr[b]  = (state_q == FTS_CLEAR) && (clr_idx_q == 4'(b));
    assign edge_blk[b] = |edge_q[3*b +: 3];

    cv32e40p_ft_err_counter #(.CntW(CNT_W)) u_det_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (err_detected_i[b]),
      .clr_i (cnt_clr[b]),
      .cnt_o (det_cnt[b])
    );

    cv32e40p_ft_err_counter #(.CntW(CNT_W)) u_cor_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (err_corrected_i[b]),
      .clr_i (cnt_clr[b]),
      .cnt_o (cor_cnt[b])
    );
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    irq_en_d  = irq_en_q;
    force_d   = force_q;
    status_d  = status_q;

    unique case (state_q)
      FTS_IDLE: begin
        if (wr && (addr_i == FTS_CTRL) && wdata_i[0]) begin
          state_d   = FTS_CLEAR;
          clr_idx_d = '0;
        end
      end
      FTS_CLEAR: begin
        if (clr_idx_q == 4'(N_BLOCKS - 1)) begin
          state_d = FTS_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + 4'd1;
        end
      end
      default: state_d = FTS_IDLE;
    endcase

    if (wr) begin
      if (addr_i == FTS_STATUS) status_d = status_q & ~wdata_i[N_BLOCKS-1:0];
      if (addr_i == FTS_CTRL)   irq_en_d = wdata_i[1];
      for (int b = 0; b < N_BLOCKS; b++) begin
        if (addr_i == FTS_BLK_BASE + 8'(4 * b) + FTS_FORCE) force_d[3*b +: 3] = wdata_i[2:0];
      end
    end
    // A new broken edge beats a simultaneous write-1-to-clear.
    status_d = status_d | edge_blk;
  end

  always_comb begin
    rdata_d = '0;
    if (gnt && !we_i) begin
      if (addr_i == FTS_STATUS) rdata_d = 32'(status_q);
      if (addr_i == FTS_CTRL)   rdata_d = {30'd0, irq_en_q, 1'b0};
      for (int b = 0; b < N_BLOCKS; b++) begin
        if (addr_i == FTS_BLK_BASE + 8'(4 * b) + FTS_DET) rdata_d = 32'(det_cnt[b]);
        if (addr_i == FTS_BLK_BASE + 8'(4 * b) + FTS_COR) rdata_d = 32'(cor_cnt[b]);
        if (addr_i == FTS_BLK_BASE + 8'(4 * b) + FTS_BROKEN) begin
          rdata_d = {28'd0, fts_fatal(is_broken_i[3*b +: 3]), is_broken_i[3*b +: 3]};
        end
        if (addr_i == FTS_BLK_BASE + 8'(4 * b) + FTS_FORCE) rdata_d = {29'd0, force_q[3*b +: 3]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FTS_IDLE;
      clr_idx_q <= '0;
      status_q  <= '0;
      force_q   <= '0;
      irq_en_q  <= 1'b0;
      brk_q     <= '0;
      edge_q    <= '0;
      init_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      status_q  <= status_d;
      force_q   <= force_d;
      irq_en_q  <= irq_en_d;
      brk_q     <= is_broken_i;
      init_q    <= 1'b1;
      // The first sample after reset only primes brk_q, so lanes broken at release stay quiet.
      edge_q    <= init_q ? (is_broken_i & ~brk_q) : '0;
      rvalid_q  <= gnt;
      rdata_q   <= rdata_d;
    end
  end

  assign gnt_o        = gnt;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign set_broken_o = force_q;
  assign irq_o        = irq_en_q & (|status_q);

endmodule

// File: tb/tb_cv32e40p_ft_supervisor.sv
// Bench for cv32e40p_ft_supervisor: directed sequences, a register vector table and a
// randomized run, all checked against a cycle-level behavioural model.
module tb_cv32e40p_ft_supervisor;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk, rst_n;
  logic [N-1:0]   err_detected_i, err_corrected_i;
  logic [3*N-1:0] is_broken_i, set_broken_o;
  logic           req_i, we_i, gnt_o, rvalid_o, irq_o;
  logic [7:0]     addr_i;
  logic [31:0]    wdata_i, rdata_o;

  int n_cmp = 0;
  int n_err = 0;

  cv32e40p_ft_supervisor #(.N_BLOCKS(N), .CNT_W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .err_detected_i  (err_detected_i),
    .err_corrected_i (err_corrected_i),
    .is_broken_i     (is_broken_i),
    .set_broken_o    (set_broken_o),
    .req_i           (req_i),
    .we_i            (we_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .gnt_o           (gnt_o),
    .rvalid_o        (rvalid_o),
    .rdata_o         (rdata_o),
    .irq_o           (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int             m_det [N];
  int             m_cor [N];
  logic [N-1:0]   m_status, m_pend;
  logic [3*N-1:0] m_force, m_prev;
  bit             m_irq_en, m_have_prev, m_rvalid;
  int             m_clr;
  logic [31:0]    m_rdata;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int b, off;
    logic [2:0] l;
    if (a == 8'h00) return 32'(m_status);
    if (a == 8'h01) return {30'd0, m_irq_en, 1'b0};
    if (a < 8'h10 || a >= 8'(16 + 4 * N)) return 32'd0;
    b   = (int'(a) - 16) / 4;
    off = (int'(a) - 16) % 4;
    l   = is_broken_i[3*b +: 3];
    case (off)
      0:       return 32'(m_det[b]);
      1:       return 32'(m_cor[b]);
      2:       return 32'(l) | (($countones(l) >= 2) ? 32'd8 : 32'd0);
      default: return 32'(m_force[3*b +: 3]);
    endcase
  endfunction

  task automatic m_reset();
    for (int b = 0; b < N; b++) begin
      m_det[b] = 0;
      m_cor[b] = 0;
    end
    m_status = '0; m_pend = '0; m_force = '0; m_prev = '0;
    m_irq_en = 0; m_have_prev = 0; m_rvalid = 0; m_rdata = '0; m_clr = -1;
  endtask

  task automatic m_tick();
    bit g;
    logic [N-1:0] edges, w1c;
    int maxc;
    maxc = (1 << W) - 1;
    g = req_i && (m_clr < 0);
    m_rvalid = g;
    m_rdata = (g && !we_i) ? m_read(addr_i) : 32'd0;
    for (int b = 0; b < N; b++) begin
      if (err_detected_i[b] && m_det[b] < maxc) m_det[b]++;
      if (err_corrected_i[b] && m_cor[b] < maxc) m_cor[b]++;
      if (m_clr == b) begin
        m_det[b] = 0;
        m_cor[b] = 0;
      end
    end
    w1c = '0;
    if (g && we_i) begin
      if (addr_i == 8'h00) w1c = wdata_i[N-1:0];
      if (addr_i == 8'h01) m_irq_en = wdata_i[1];
      for (int b = 0; b < N; b++)
        if (addr_i == 8'(16 + 4 * b + 3)) m_force[3*b +: 3] = wdata_i[2:0];
    end
    for (int b = 0; b < N; b++)
      edges[b] = m_have_prev && (|(is_broken_i[3*b +: 3] & ~m_prev[3*b +: 3]));
    m_status = (m_status & ~w1c) | m_pend;
    m_pend = edges;
    m_prev = is_broken_i;
    m_have_prev = 1;
    if (m_clr >= 0) m_clr = (m_clr + 1 == N) ? -1 : m_clr + 1;
    else if (g && we_i && addr_i == 8'h01 && wdata_i[0]) m_clr = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_tick();
  end

  always @(negedge clk) begin
    chk("mon_gnt", 32'(gnt_o), 32'(rst_n && req_i && (m_clr < 0)));
    chk("mon_irq", 32'(irq_o), 32'(m_irq_en && (|m_status)));
    chk("mon_set_broken", 32'(set_broken_o), 32'(m_force));
    chk("mon_rvalid", 32'(rvalid_o), 32'(m_rvalid));
    if (m_rvalid) chk("mon_rdata", rdata_o, m_rdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1.
  task automatic access(input bit we, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    int n;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
    n = 0;
    @(negedge clk);
    while (!gnt_o && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (!gnt_o) chk("gnt_timeout", 32'(gnt_o), 32'd1);
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    chk("acc_rvalid", 32'(rvalid_o), 32'd1);
    rd = rdata_o;
    tick();
  endtask

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [17];
  logic [7:0] addr_pool [20];

  initial begin
    logic [31:0] rd;
    int n;

    err_detected_i = '0; err_corrected_i = '0; is_broken_i = '0;
    req_i = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_set_broken", 32'(set_broken_o), 32'd0);
    req_i = 1'b0;
    rst_n = 1'b1;
    tick();

    // Detected-error count on block 1.
    err_detected_i[1] = 1'b1;
    repeat (5) tick();
    err_detected_i = '0;
    access(0, 8'h14, 0, rd); chk("det1_eq5", rd, 32'd5);
    access(0, 8'h10, 0, rd); chk("det0_zero", rd, 32'd0);
    access(0, 8'h18, 0, rd); chk("det2_zero", rd, 32'd0);
    access(0, 8'h1C, 0, rd); chk("det3_zero", rd, 32'd0);

    // Saturation of a 4-bit corrected counter.
    err_corrected_i[0] = 1'b1;
    repeat (20) tick();
    err_corrected_i = '0;
    access(0, 8'h11, 0, rd); chk("cor0_sat", rd, 32'd15);

    // Pending and irq from a lane break on block 3.
    access(1, 8'h01, 32'h2, rd);
    is_broken_i[11] = 1'b1;
    tick(); chk("irq_after_1", 32'(irq_o), 32'd0);
    tick(); chk("irq_after_2", 32'(irq_o), 32'd1);
    access(0, 8'h00, 0, rd); chk("status_b3", rd, 32'h8);
    access(0, 8'h1E, 0, rd); chk("broken_b3", rd, 32'h4);
    access(1, 8'h00, 32'h8, rd);
    chk("irq_w1c", 32'(irq_o), 32'd0);

    // Fatal reporting and forced lanes on block 0.
    is_broken_i[1:0] = 2'b11;
    tick(); tick();
    access(0, 8'h12, 0, rd); chk("broken_b0_fatal", rd, 32'hB);
    access(1, 8'h13, 32'h5, rd);
    chk("force_b0", 32'(set_broken_o[2:0]), 32'h5);

    // clear_all sweep with block 0 still counting and req held high.
    err_detected_i[0] = 1'b1;
    tick();
    req_i = 1'b1; we_i = 1'b1; addr_i = 8'h01; wdata_i = 32'h3;
    @(negedge clk); chk("clr_write_gnt", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    we_i = 1'b0; addr_i = 8'h10;
    n = 0;
    @(negedge clk);
    while (!gnt_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("clear_len", 32'(n), 32'(N));
    @(posedge clk); #1;
    req_i = 1'b0; err_detected_i = '0;
    @(negedge clk);
    chk("clr_rvalid", 32'(rvalid_o), 32'd1);
    chk("det0_after_clear", rdata_o, 32'(N - 1));
    tick();
    access(0, 8'h11, 0, rd); chk("cor0_cleared", rd, 32'd0);
    access(0, 8'h14, 0, rd); chk("det1_cleared", rd, 32'd0);
    access(0, 8'h00, 0, rd); chk("status_kept", rd, 32'h1);
    access(0, 8'h01, 0, rd); chk("irq_en_kept", rd, 32'h2);
    chk("irq_kept", 32'(irq_o), 32'd1);

    // Reset in the middle of a clear sweep.
    req_i = 1'b1; we_i = 1'b1; addr_i = 8'h01; wdata_i = 32'h1;
    tick();
    we_i = 1'b0; addr_i = 8'h00;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt", 32'(gnt_o), 32'd0);
    chk("mrst_rvalid", 32'(rvalid_o), 32'd0);
    chk("mrst_rdata", rdata_o, 32'd0);
    chk("mrst_irq", 32'(irq_o), 32'd0);
    chk("mrst_set_broken", 32'(set_broken_o), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk); chk("gnt_follows_req", 32'(gnt_o), 32'd1);
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk); chk("gnt_follows_req0", 32'(gnt_o), 32'd0);
    @(posedge clk); #1;
    repeat (4) tick();
    access(0, 8'h00, 0, rd); chk("no_pending_at_release", rd, 32'h0);

    // Register vector table from a clean reset.
    is_broken_i = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    vecs[0]  = '{0, 8'h00, 32'h0,        32'h0};
    vecs[1]  = '{0, 8'h01, 32'h0,        32'h0};
    vecs[2]  = '{1, 8'h01, 32'hFFFFFFFE, 32'h0};
    vecs[3]  = '{0, 8'h01, 32'h0,        32'h2};
    vecs[4]  = '{1, 8'h17, 32'hFFFFFFFF, 32'h0};
    vecs[5]  = '{0, 8'h17, 32'h0,        32'h7};
    vecs[6]  = '{0, 8'h16, 32'h0,        32'h0};
    vecs[7]  = '{1, 8'h14, 32'h55,       32'h0};
    vecs[8]  = '{0, 8'h14, 32'h0,        32'h0};
    vecs[9]  = '{0, 8'h05, 32'h0,        32'h0};
    vecs[10] = '{0, 8'h20, 32'h0,        32'h0};
    vecs[11] = '{1, 8'h1F, 32'h3,        32'h0};
    vecs[12] = '{0, 8'h1F, 32'h0,        32'h3};
    vecs[13] = '{1, 8'h00, 32'hF,        32'h0};
    vecs[14] = '{0, 8'h00, 32'h0,        32'h0};
    vecs[15] = '{1, 8'h01, 32'h0,        32'h0};
    vecs[16] = '{0, 8'h01, 32'h0,        32'h0};
    for (int i = 0; i < 17; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      chk($sformatf("vec%0d_addr%0h", i, vecs[i].addr), rd, vecs[i].exp);
    end

    // Randomized run; the model and monitor carry all checks.
    for (int i = 0; i < 20; i++) addr_pool[i] = 8'(8'h0E + i);
    addr_pool[0] = 8'h00;
    addr_pool[1] = 8'h01;
    addr_pool[18] = 8'hFF;
    for (int c = 0; c < 3000; c++) begin
      err_detected_i  = N'($urandom) & N'($urandom);
      err_corrected_i = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 19) == 0) is_broken_i[$urandom_range(0, 3 * N - 1)] ^= 1'b1;
      req_i   = ($urandom_range(0, 2) == 0);
      we_i    = 1'($urandom);
      addr_i  = addr_pool[$urandom_range(0, 19)];
      wdata_i = $urandom;
      if (addr_i == 8'h01 && $urandom_range(0, 7) != 0) wdata_i[0] = 1'b0;
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    req_i = 1'b0; rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_ft_supervisor.md
# cv32e40p_ft_supervisor

Central supervisor on the other end of the fault-tolerance status interface that every TMR wrapper exposes (err_detected_o, err_corrected_o, is_broken_o in; set_broken_i out). It collects the status of N_BLOCKS wrappers and counts detected and corrected errors per block. It raises an interrupt when any replica lane breaks, and lets software read state and force lanes broken through a single-cycle request/grant register port. One instance sits beside the core, wired to all FT wrappers.

## Interface
- N_BLOCKS, 4, number of supervised FT wrappers (1..8)
- CNT_W, 16, width of each saturating error counter (4..32)
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- err_detected_i  in  N_BLOCKS  per-wrapper err_detected_o
- err_corrected_i  in  N_BLOCKS  per-wrapper err_corrected_o
- is_broken_i  in  3*N_BLOCKS  per-wrapper is_broken_o; block b uses bits [3b+2:3b]
- set_broken_o  out  3*N_BLOCKS  per-wrapper set_broken_i, registered
- req_i  in  1  register access request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  8  word address
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid, one cycle after grant
- rdata_o  out  32  read data, valid with rvalid_o; 0 for writes and unmapped addresses
- irq_o  out  1  level interrupt: CTRL.irq_en & (STATUS != 0)

## Operation
- Register map:
  - 0x00 STATUS: bit b = pending for block b; write-1-to-clear.
  - 0x01 CTRL: bit0 clear_all (write-only, self-clearing, reads 0); bit1 irq_en (RW).
  - Per block b, base 0x10+4b:
    - +0 DET_CNT (RO)
    - +1 COR_CNT (RO)
    - +2 BROKEN: bits[2:0] = is_broken_i of block b, bit3 = fatal, i.e. at least 2 lanes broken (RO).
    - +3 FORCE: bits[2:0] drive set_broken_o of block b (RW).
  - Unused bits read 0; writes to RO or unmapped addresses are ignored.
- Counters: DET_CNT increments by 1 each cycle err_detected_i[b]=1; COR_CNT likewise for err_corrected_i. Both saturate at 2^CNT_W-1; no wrap.
- Pending: STATUS[b] sets on any 0->1 edge of any lane of is_broken_i for block b, using a registered copy of is_broken_i. A lane already broken at reset release does not set pending.
- FSM states:
  - IDLE: gnt_o = req_i.
  - CLEAR: gnt_o = 0. Entered on a write of CTRL bit0=1. Zeroes DET_CNT/COR_CNT of one block per cycle, index 0..N_BLOCKS-1, then returns to IDLE. STATUS, FORCE and irq_en are untouched.
- Collisions:
  - Increment and clear on the same counter in the same cycle: clear wins.
  - STATUS W1C and a new edge for the same bit in the same cycle: set wins.
  - Counting continues during CLEAR for blocks not yet cleared or already cleared.
- Reset mid-CLEAR: FSM returns to IDLE and all state takes its reset values.

## Timing
- Reset values: set_broken_o=0, gnt_o=0 during reset (IDLE after), rvalid_o=0, rdata_o=0, irq_o=0. All counters, STATUS, FORCE and irq_en reset to 0.
- Grant is combinational from req_i in IDLE. Write data takes effect at the grant edge, so FORCE reaches set_broken_o on the cycle after grant.
- rvalid_o is high exactly one cycle after each grant, reads and writes alike. Back-to-back grants give back-to-back rvalid_o.
- Read data samples register state at the grant edge.
- CLEAR lasts exactly N_BLOCKS cycles. The first grant after a clear_all write comes no earlier than N_BLOCKS+1 cycles after it.
- Edge to STATUS: 2 cycles from is_broken_i change (edge register, then STATUS). irq_o asserts combinationally from STATUS.

## Structure
- The shared package cv32e40p_pkg2_ft holds:
  - address constants: FTS_STATUS, FTS_CTRL, FTS_BLK_BASE, FTS_DET/COR/BROKEN/FORCE offsets;
  - the FSM enum fts_state_e {FTS_IDLE, FTS_CLEAR}.
- Sub-module cv32e40p_ft_err_counter: saturating CNT_W counter with inc_i and clr_i inputs (clear priority), instantiated 2*N_BLOCKS times.

## Test plan
- Pulse err_detected_i[1] for 5 cycles, read 0x14 -> rdata_o=5 on rvalid_o one cycle after grant. DET_CNT of the other blocks reads 0.
- CNT_W=4, hold err_corrected_i[0] for 20 cycles -> COR_CNT reads 15.
- Write 0x01=0x2, then raise is_broken_i lane 2 of block 3 -> STATUS=0x8 and irq_o=1 two cycles later. BROKEN 0x1E reads 0x4. Write STATUS=0x8 -> irq_o drops next cycle.
- Raise lanes 0 and 1 of block 0 -> 0x12 reads 0xB (fatal bit set). Write 0x13=0x5 -> set_broken_o[2:0]=3'b101 one cycle after grant.
- Write CTRL=0x1 while keeping req_i high -> gnt_o=0 for exactly N_BLOCKS cycles. All counters then read 0 while STATUS is preserved. err_detected_i held on block 0 during the sweep -> block 0 counts from 0 the cycle after its clear.
- Assert rst_n=0 mid-CLEAR -> all outputs 0 immediately. After release, gnt_o follows req_i.
